// File: rtl/cnt_mod_updown.sv
// cnt_mod_updown: N-bit up/down counter with a runtime modulus (0..max),
// synchronous parallel load, and wrap / saturate / one-shot terminal handling.
// q, evt and done are registered; tc is a combinational view of q, max and dir.
module cnt_mod_updown #(
    parameter int N          = 8,
    parameter bit CLAMP_LOAD = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [N-1:0] din,
    input  logic [N-1:0] max,
    input  logic [1:0]   mode,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         evt,
    output logic         done
);

    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ZERO = {N{1'b0}};

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    logic [N-1:0] count_q, count_d;
    logic         evt_q, evt_d;
    logic         done_q, done_d;

    // Terminal flag: counting up, any value at or above max is terminal, so a
    // max lowered below q still stops/wraps the counter instead of overflowing.
    always_comb begin
        tc = dir ? (count_q >= max) : (count_q == ZERO);
    end

    // Next-state: load beats enable; a finished one-shot ignores enable.
    always_comb begin
        count_d = count_q;
        evt_d   = 1'b0;
        done_d  = done_q;
        if (load) begin
            count_d = (CLAMP_LOAD && (din > max)) ? max : din;
            done_d  = 1'b0;
        end else if (en && !done_q) begin
            if (!dir && (count_q > max)) begin
                // Down-count from above a lowered max snaps into range; not a terminal event.
                count_d = max;
            end else if (tc) begin
                evt_d = 1'b1;
                case (mode)
                    MODE_SAT: begin
                        count_d = count_q;
                    end
                    MODE_ONESHOT: begin
                        count_d = count_q;
                        done_d  = 1'b1;
                    end
                    default: begin
                        count_d = dir ? ZERO : max;
                    end
                endcase
            end else if (dir) begin
                count_d = count_q + ONE;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ZERO;
            evt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            evt_q   <= evt_d;
            done_q  <= done_d;
        end
    end

    assign q    = count_q;
    assign evt  = evt_q;
    assign done = done_q;

endmodule

// File: tb/tb_cnt_mod_updown.sv
// Directed, table-driven bench for cnt_mod_updown (N=8, CLAMP_LOAD=1).
module tb_cnt_mod_updown;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] max = '0;
    logic [1:0] mode = '0;
    logic [7:0] q;
    logic       tc;
    logic       evt;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cnt_mod_updown #(.N(8), .CLAMP_LOAD(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .dir (dir),
        .load(load),
        .din (din),
        .max (max),
        .mode(mode),
        .q   (q),
        .tc  (tc),
        .evt (evt),
        .done(done)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       dir;
        logic       load;
        logic [7:0] din;
        logic [7:0] max;
        logic [1:0] mode;
        logic [7:0] q;
        logic       tc;
        logic       evt;
        logic       done;
    } vec_t;

    vec_t vecs[100];
    int   nv = 0;

    task automatic v(input logic r, input logic e, input logic d, input logic l,
                     input logic [7:0] di, input logic [7:0] mx, input logic [1:0] md,
                     input logic [7:0] eq, input logic etc, input logic eevt, input logic edone);
        vecs[nv] = '{r, e, d, l, di, mx, md, eq, etc, eevt, edone};
        nv++;
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, compare #1 after the following rising edge.
    task automatic drive(input logic r, input logic e, input logic d, input logic l,
                         input logic [7:0] di, input logic [7:0] mx, input logic [1:0] md);
        @(negedge clk);
        rst = r; en = e; dir = d; load = l; din = di; max = mx; mode = md;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Wrap up, max=9
        v(1,0,1,0,0,9,0, 0,0,0,0);
        for (int k = 1; k <= 8; k++) v(0,1,1,0,0,9,0, 8'(k),0,0,0);
        v(0,1,1,0,0,9,0, 9,1,0,0);
        v(0,1,1,0,0,9,0, 0,0,1,0);
        v(0,1,1,0,0,9,0, 1,0,0,0);
        // Wrap down, full range
        v(1,0,0,0,0,255,0, 0,1,0,0);
        v(0,1,0,0,0,255,0, 255,0,1,0);
        v(0,1,0,0,0,255,0, 254,0,0,0);
        v(0,1,1,0,0,255,0, 255,1,0,0);
        v(0,1,1,0,0,255,0, 0,0,1,0);
        // Saturate, max=5
        v(1,0,1,0,0,5,1, 0,0,0,0);
        for (int k = 1; k <= 4; k++) v(0,1,1,0,0,5,1, 8'(k),0,0,0);
        v(0,1,1,0,0,5,1, 5,1,0,0);
        for (int k = 0; k < 5; k++) v(0,1,1,0,0,5,1, 5,1,1,0);
        for (int k = 4; k >= 1; k--) v(0,1,0,0,0,5,1, 8'(k),0,0,0);
        v(0,1,0,0,0,5,1, 0,1,0,0);
        v(0,1,0,0,0,5,1, 0,1,1,0);
        v(0,1,0,0,0,5,1, 0,1,1,0);
        // One-shot and re-arm, max=3
        v(1,0,1,0,0,3,2, 0,0,0,0);
        v(0,1,1,0,0,3,2, 1,0,0,0);
        v(0,1,1,0,0,3,2, 2,0,0,0);
        v(0,1,1,0,0,3,2, 3,1,0,0);
        v(0,1,1,0,0,3,2, 3,1,1,1);
        v(0,1,1,0,0,3,2, 3,1,0,1);
        v(0,1,1,0,0,3,0, 3,1,0,1);
        v(0,1,1,1,1,3,2, 1,0,0,0);
        v(0,1,1,0,0,3,2, 2,0,0,0);
        v(0,1,1,0,0,3,2, 3,1,0,0);
        // Load clamp and priority
        v(1,0,1,0,0,20,0, 0,0,0,0);
        v(0,1,1,1,50,20,0, 20,1,0,0);
        v(0,1,1,0,0,20,0, 0,0,1,0);
        v(0,0,1,1,12,20,0, 12,0,0,0);
        v(1,1,1,1,7,20,0, 0,0,0,0);
        // Runtime max change
        v(1,0,1,0,0,31,0, 0,0,0,0);
        v(0,0,1,1,15,31,0, 15,0,0,0);
        v(0,0,1,0,0,10,0, 15,1,0,0);
        v(0,1,1,0,0,10,0, 0,0,1,0);
        v(0,0,1,1,15,31,0, 15,0,0,0);
        v(0,1,0,0,0,10,0, 10,0,0,0);
        v(0,0,1,1,15,31,1, 15,0,0,0);
        v(0,1,1,0,0,10,1, 15,1,1,0);
        v(0,0,1,0,0,10,1, 15,1,0,0);

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].load,
                  vecs[i].din, vecs[i].max, vecs[i].mode);
            check("q",    i, int'(q),    int'(vecs[i].q));
            check("tc",   i, int'(tc),   int'(vecs[i].tc));
            check("evt",  i, int'(evt),  int'(vecs[i].evt));
            check("done", i, int'(done), int'(vecs[i].done));
            $display("vec %0d: rst=%0b en=%0b dir=%0b load=%0b din=%0d max=%0d mode=%0d -> q=%0d tc=%0b evt=%0b done=%0b",
                     i, vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].load, vecs[i].din,
                     vecs[i].max, vecs[i].mode, q, tc, evt, done);
        end

        // max=0 in wrap mode: q stays 0, tc and evt high every enabled cycle
        drive(1,0,1,0,0,0,0);
        check("max0_reset_q", 0, int'(q), 0);
        for (int k = 1; k <= 4; k++) begin
            drive(0,1,1,0,0,0,0);
            check("max0_q",   k, int'(q),   0);
            check("max0_tc",  k, int'(tc),  1);
            check("max0_evt", k, int'(evt), 1);
            $display("max0 step %0d: q=%0d tc=%0b evt=%0b", k, q, tc, evt);
        end

        // Full-range free-running count: 256 steps, one wrap with a single evt
        drive(1,0,1,0,0,255,0);
        begin
            int evt_count;
            evt_count = 0;
            for (int k = 1; k <= 257; k++) begin
                drive(0,1,1,0,0,255,0);
                check("full_q",   k, int'(q),   k % 256);
                check("full_evt", k, int'(evt), (k == 256) ? 1 : 0);
                if (evt) evt_count++;
            end
            check("full_evt_count", 0, evt_count, 1);
            $display("full range: %0d wrap events over 257 steps, final q=%0d", evt_count, q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnt_mod_updown.md
Name: cnt_mod_updown

Overview:
- Parametrised successor to the team's fixed-range free-running counter.
- Adds direction control, a runtime modulus, parallel load, and three terminal-count modes (wrap / saturate / one-shot).
- Terminal detection is correct for any width N and any runtime `max`; no value is hard-coded.
- Used as a timer, prescaler or loop counter by the calculator datapath and control FSMs. Multiple instances can be cascaded via `en`/`evt`.

Parameters:
- N, 8, counter width in bits (N >= 2).
- CLAMP_LOAD, 1, 1: a load value above `max` is clamped to `max`; 0: the load value is taken verbatim.

Ports:
- clk   in   1   system clock; all state updates on its rising edge.
- rst   in   1   reset, synchronous, active-high.
- en    in   1   count enable; one step per clock while high.
- dir   in   1   1 = count up, 0 = count down; sampled each enabled cycle.
- load  in   1   synchronous parallel load of `din`.
- din   in   N   load value.
- max   in   N   terminal value; counting range is 0..max inclusive. May change at runtime.
- mode  in   2   00 = wrap, 01 = saturate, 10 = one-shot, 11 = behaves as wrap.
- q     out  N   current count (registered).
- tc    out  1   combinational terminal flag: dir=1 -> (q >= max); dir=0 -> (q == 0).
- evt   out  1   registered one-cycle pulse: an enabled step was attempted at terminal.
- done  out  1   registered; one-shot finished, counter frozen.

Behaviour:
- Reset (rst=1 at a clock edge): q=0, evt=0, done=0. Reset has priority over everything else, including mid-count and mid-load.
- Priority each edge: rst > load > en. With none active, q/done hold and evt=0.
- Load:
  - q <= (CLAMP_LOAD && din > max) ? max : din.
  - done <= 0, evt <= 0.
  - `en` is ignored that cycle.
- Enabled step, not terminal:
  - Up: q <= q+1. Down: q <= q-1. evt <= 0.
  - Down with q > max (max lowered at runtime): q <= max, evt <= 0; this clamp is not a terminal event.
- Enabled step at terminal (tc=1, done=0): evt <= 1 in every mode, then:
  - wrap: up -> q <= 0; down -> q <= max.
  - saturate: q holds.
  - one-shot: q holds, done <= 1.
- Up with q > max (max lowered at runtime) counts as terminal: wrap mode -> q <= 0; saturate/one-shot -> q holds, not clamped.
- Done state:
  - While done=1, `en` is ignored: q holds, evt=0.
  - done clears only on load or rst. Changing `mode` does not clear it.
- evt timing:
  - Asserted exactly one cycle after the terminal step, for one cycle per terminal step.
  - Continuous en at terminal in saturate mode -> evt high every cycle.
  - In one-shot mode evt fires once only.
- Boundaries:
  - max=0: up tc is always 1. Wrap mode gives q=0 with evt every enabled cycle.
  - max = 2^N-1 reproduces a full-range free-running counter.
  - Arithmetic is N-bit unsigned. No overflow is possible because of the terminal handling.
  - dir toggling mid-count takes effect on the next enabled edge; tc follows dir combinationally.
- Latency: q updates 1 cycle after the sampled inputs. tc is combinational from q, max and dir. evt and done are registered.

Test Plan:
- Wrap up: N=8, rst, max=9, mode=00, dir=1, en=1 for 12 cycles -> q 0..9,0,1. tc high at q=9. evt high exactly the cycle q returns to 0.
- Wrap down and full range: max=255, dir=0 from reset, en=1 -> q 0,255,254. evt pulses once after the 0->255 step. With dir=1, 255->0 also pulses evt.
- Saturate: max=5, mode=01, dir=1, en held 10 cycles -> q sticks at 5 from cycle 5. evt high on each cycle after the first attempt at 5. dir=0 then counts 4,3,...,0 and sticks at 0.
- One-shot and re-arm: max=3, mode=10, en=1 -> q 0,1,2,3, done=1 next cycle, evt single pulse, q frozen while en stays high. load with din=1 -> done=0, counting resumes 2,3.
- Load clamp and priority: max=20, load=1, din=50, en=1 -> q=20 (CLAMP_LOAD=1), no increment that cycle. rst=1 together with load -> q=0.
- Runtime max change: count up to q=15 with max=31, drop max to 10 -> tc=1 immediately. Next enabled edge in wrap mode -> q=0 and evt. Down with q=15, max=10 -> q=10, no evt.
